// File: rtl/rob_if.sv
// Issue / CDB / query / commit bundle between the reorder buffer and its neighbours.
interface rob_if;
   logic        hci_rdy;
   logic        issue_en;
   logic        issue_has_dest;
   logic [4:0]  issue_rd;
   logic        issue_is_branch;
   logic        issue_pred_taken;
   logic [31:0] issue_alt_pc;
   logic [4:0]  issue_tag;
   logic        full;
   logic        empty;
   logic        cdb_en;
   logic [4:0]  cdb_tag;
   logic [31:0] cdb_val;
   logic        cdb_taken;
   logic [4:0]  query1_tag;
   logic [4:0]  query2_tag;
   logic        query1_ready;
   logic        query2_ready;
   logic [31:0] query1_val;
   logic [31:0] query2_val;
   logic        commit_en;
   logic [4:0]  commit_rd;
   logic [4:0]  commit_tag;
   logic [31:0] commit_val;
   logic        flush;
   logic [31:0] flush_pc;

   modport slave (
      input  hci_rdy, issue_en, issue_has_dest, issue_rd, issue_is_branch,
             issue_pred_taken, issue_alt_pc, cdb_en, cdb_tag, cdb_val, cdb_taken,
             query1_tag, query2_tag,
      output issue_tag, full, empty, query1_ready, query2_ready, query1_val,
             query2_val, commit_en, commit_rd, commit_tag, commit_val, flush, flush_pc
   );

   modport master (
      output hci_rdy, issue_en, issue_has_dest, issue_rd, issue_is_branch,
             issue_pred_taken, issue_alt_pc, cdb_en, cdb_tag, cdb_val, cdb_taken,
             query1_tag, query2_tag,
      input  issue_tag, full, empty, query1_ready, query2_ready, query1_val,
             query2_val, commit_en, commit_rd, commit_tag, commit_val, flush, flush_pc
   );
endinterface

// File: rtl/rob.sv
// 32-entry reorder buffer: tag allocation, CDB capture, in-order retire,
// operand lookup with same-cycle CDB bypass, and mispredict flush.
module rob (
   input  logic clk,
   input  logic rst,
   rob_if.slave bus
);
   localparam int unsigned DEPTH = 32;
   localparam int unsigned TAG_W = 5;
   localparam int unsigned CNT_W = 6;
   localparam int unsigned XLEN  = 32;

   typedef struct packed {
      logic            valid;
      logic            ready;
      logic            has_dest;
      logic [TAG_W-1:0] rd;
      logic [XLEN-1:0]  val;
      logic            is_branch;
      logic            pred_taken;
      logic            taken;
      logic [XLEN-1:0]  alt_pc;
   } entry_t;

   entry_t            ent_q [DEPTH];
   entry_t            ent_d [DEPTH];
   logic [TAG_W-1:0]  head_q, head_d;
   logic [TAG_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;

   entry_t            head_e;
   logic              full_c;
   logic              retire_c;
   logic              mis_c;
   logic              pop_c;
   logic              alloc_c;
   logic              cdb_wr_c;
   logic              q1_hit_c, q2_hit_c;

   assign head_e   = ent_q[head_q];
   assign full_c   = (count_q == CNT_W'(DEPTH));
   assign retire_c = bus.hci_rdy && !rst && head_e.valid && head_e.ready;
   assign mis_c    = retire_c && head_e.is_branch && (head_e.taken != head_e.pred_taken);
   assign pop_c    = retire_c && !mis_c;
   assign alloc_c  = bus.issue_en && !full_c && !mis_c && bus.hci_rdy;
   assign cdb_wr_c = bus.cdb_en && ent_q[bus.cdb_tag].valid && bus.hci_rdy;

   assign bus.issue_tag  = tail_q;
   assign bus.full       = full_c;
   assign bus.empty      = (count_q == '0);
   assign bus.commit_en  = retire_c && head_e.has_dest;
   assign bus.commit_rd  = head_e.rd;
   assign bus.commit_tag = head_q;
   assign bus.commit_val = head_e.val;
   assign bus.flush      = mis_c;
   assign bus.flush_pc   = mis_c ? head_e.alt_pc : '0;

   // Operand lookup bypasses a result arriving on the CDB this cycle.
   assign q1_hit_c = bus.cdb_en && (bus.cdb_tag == bus.query1_tag);
   assign q2_hit_c = bus.cdb_en && (bus.cdb_tag == bus.query2_tag);
   assign bus.query1_ready = ent_q[bus.query1_tag].valid && (ent_q[bus.query1_tag].ready || q1_hit_c);
   assign bus.query2_ready = ent_q[bus.query2_tag].valid && (ent_q[bus.query2_tag].ready || q2_hit_c);
   assign bus.query1_val   = q1_hit_c ? bus.cdb_val : ent_q[bus.query1_tag].val;
   assign bus.query2_val   = q2_hit_c ? bus.cdb_val : ent_q[bus.query2_tag].val;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;

      if (cdb_wr_c) begin
         ent_d[bus.cdb_tag].val   = bus.cdb_val;
         ent_d[bus.cdb_tag].taken = bus.cdb_taken;
         ent_d[bus.cdb_tag].ready = 1'b1;
      end

      if (alloc_c) begin
         ent_d[tail_q].valid      = 1'b1;
         ent_d[tail_q].ready      = 1'b0;
         ent_d[tail_q].has_dest   = bus.issue_has_dest;
         ent_d[tail_q].rd         = bus.issue_rd;
         ent_d[tail_q].val        = '0;
         ent_d[tail_q].is_branch  = bus.issue_is_branch;
         ent_d[tail_q].pred_taken = bus.issue_pred_taken;
         ent_d[tail_q].taken      = 1'b0;
         ent_d[tail_q].alt_pc     = bus.issue_alt_pc;
         tail_d                   = tail_q + TAG_W'(1);
      end

      if (pop_c) begin
         ent_d[head_q].valid = 1'b0;
         head_d              = head_q + TAG_W'(1);
      end

      count_d = count_q + CNT_W'(alloc_c) - CNT_W'(pop_c);

      // A mispredict squashes everything, including this cycle's allocate/CDB write.
      if (mis_c) begin
         for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
endmodule

// File: tb/tb_rob.sv
// Reorder buffer bench: directed scenarios plus randomized traffic checked
// against a program-order queue model.
module tb_rob;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   rob_if bus();
   rob dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  tag;
      bit          has_dest;
      logic [4:0]  rd;
      bit          br;
      bit          pred;
      bit          taken;
      bit          rdy;
      logic [31:0] val;
      logic [31:0] alt;
   } ent_t;

   typedef struct {
      bit          retire;
      bit          commit_en;
      bit          flush;
      logic [31:0] flush_pc;
      bit          full;
      bit          empty;
      logic [4:0]  issue_tag;
      logic [4:0]  c_rd;
      logic [4:0]  c_tag;
      logic [31:0] c_val;
      bit          q1r;
      bit          q2r;
      logic [31:0] q1v;
      logic [31:0] q2v;
   } exp_t;

   ent_t mq[$];
   int   next_tag = 0;

   function automatic int find(input logic [4:0] t);
      foreach (mq[i]) if (mq[i].tag == t) return i;
      return -1;
   endfunction

   function automatic void model_query(input logic [4:0] t, output bit r, output logic [31:0] v);
      int k;
      k = find(t);
      r = 1'b0;
      v = '0;
      if (k >= 0) begin
         if (bus.cdb_en && bus.cdb_tag == t) begin r = 1'b1; v = bus.cdb_val; end
         else if (mq[k].rdy) begin r = 1'b1; v = mq[k].val; end
      end
   endfunction

   function automatic exp_t expect_now();
      exp_t e;
      e = '{default: '0};
      e.full      = (mq.size() == 32);
      e.empty     = (mq.size() == 0);
      e.issue_tag = 5'(next_tag);
      if (mq.size() > 0) begin
         e.retire    = !rst && bus.hci_rdy && mq[0].rdy;
         e.commit_en = e.retire && mq[0].has_dest;
         e.flush     = e.retire && mq[0].br && (mq[0].taken != mq[0].pred);
         e.flush_pc  = e.flush ? mq[0].alt : 32'h0;
         e.c_rd      = mq[0].rd;
         e.c_tag     = mq[0].tag;
         e.c_val     = mq[0].val;
      end
      model_query(bus.query1_tag, e.q1r, e.q1v);
      model_query(bus.query2_tag, e.q2r, e.q2v);
      return e;
   endfunction

   task automatic drive_idle();
      rst                  = 1'b0;
      bus.hci_rdy          = 1'b1;
      bus.issue_en         = 1'b0;
      bus.issue_has_dest   = 1'b0;
      bus.issue_rd         = '0;
      bus.issue_is_branch  = 1'b0;
      bus.issue_pred_taken = 1'b0;
      bus.issue_alt_pc     = '0;
      bus.cdb_en           = 1'b0;
      bus.cdb_tag          = '0;
      bus.cdb_val          = '0;
      bus.cdb_taken        = 1'b0;
      bus.query1_tag       = '0;
      bus.query2_tag       = '0;
   endtask

   // Advance one clock, moving the model by the spec rules, then idle the inputs.
   task automatic tick();
      exp_t e;
      bit   do_alloc;
      int   k;
      ent_t n;
      e = expect_now();
      do_alloc = bus.issue_en && bus.hci_rdy && (mq.size() < 32);
      @(posedge clk);
      if (rst || e.flush) begin
         mq.delete();
         next_tag = 0;
      end else begin
         if (e.retire) void'(mq.pop_front());
         if (bus.cdb_en && bus.hci_rdy) begin
            k = find(bus.cdb_tag);
            if (k >= 0) begin
               mq[k].rdy   = 1'b1;
               mq[k].val   = bus.cdb_val;
               mq[k].taken = bus.cdb_taken;
            end
         end
         if (do_alloc) begin
            n.tag = 5'(next_tag); n.has_dest = bus.issue_has_dest; n.rd = bus.issue_rd;
            n.br = bus.issue_is_branch; n.pred = bus.issue_pred_taken; n.taken = 1'b0;
            n.rdy = 1'b0; n.val = '0; n.alt = bus.issue_alt_pc;
            mq.push_back(n);
            next_tag = (next_tag + 1) % 32;
         end
      end
      @(negedge clk);
      drive_idle();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
   endtask

   task automatic issue(input bit hd, input logic [4:0] rd);
      bus.issue_en = 1'b1; bus.issue_has_dest = hd; bus.issue_rd = rd;
      tick();
   endtask

   task automatic test_reset();
      drive_idle();
      do_reset();
      #1;
      checks++; if (bus.full !== 1'b0)       begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
      checks++; if (bus.empty !== 1'b1)      begin errors++; $display("FAIL reset_empty got %b want 1", bus.empty); end
      checks++; if (bus.issue_tag !== 5'd0)  begin errors++; $display("FAIL reset_issue_tag got %0d want 0", bus.issue_tag); end
      checks++; if (bus.commit_en !== 1'b0)  begin errors++; $display("FAIL reset_commit_en got %b want 0", bus.commit_en); end
      checks++; if (bus.commit_rd !== 5'd0 || bus.commit_tag !== 5'd0 || bus.commit_val !== 32'h0)
         begin errors++; $display("FAIL reset_commit_fields got rd=%0d tag=%0d val=%h want 0", bus.commit_rd, bus.commit_tag, bus.commit_val); end
      checks++; if (bus.flush !== 1'b0 || bus.flush_pc !== 32'h0)
         begin errors++; $display("FAIL reset_flush got %b/%h want 0/0", bus.flush, bus.flush_pc); end
      checks++; if (bus.query1_ready !== 1'b0 || bus.query2_ready !== 1'b0)
         begin errors++; $display("FAIL reset_query_ready got %b%b want 00", bus.query1_ready, bus.query2_ready); end
   endtask

   task automatic test_basic();
      do_reset();
      issue(1'b1, 5'd5);
      bus.cdb_en = 1'b1; bus.cdb_tag = 5'd0; bus.cdb_val = 32'h1234;
      #1;
      checks++; if (bus.commit_en !== 1'b0) begin errors++; $display("FAIL basic_early_commit got %b want 0", bus.commit_en); end
      tick();
      #1;
      checks++; if (bus.commit_en !== 1'b1 || bus.commit_rd !== 5'd5 || bus.commit_tag !== 5'd0 || bus.commit_val !== 32'h1234)
         begin errors++; $display("FAIL basic_commit got en=%b rd=%0d tag=%0d val=%h want 1/5/0/1234",
                                  bus.commit_en, bus.commit_rd, bus.commit_tag, bus.commit_val); end
      tick();
      #1;
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL basic_empty got %b want 1", bus.empty); end
   endtask

   task automatic test_in_order();
      logic [31:0] vals [3];
      vals[0] = 32'h20; vals[1] = 32'h21; vals[2] = 32'h22;
      do_reset();
      for (int i = 0; i < 3; i++) issue(1'b1, 5'(i + 1));
      bus.cdb_en = 1'b1; bus.cdb_tag = 5'd2; bus.cdb_val = vals[2];
      #1;
      checks++; if (bus.commit_en !== 1'b0) begin errors++; $display("FAIL order_head_not_ready got %b want 0", bus.commit_en); end
      tick();
      bus.cdb_en = 1'b1; bus.cdb_tag = 5'd0; bus.cdb_val = vals[0];
      tick();
      for (int i = 0; i < 3; i++) begin
         if (i == 0) begin bus.cdb_en = 1'b1; bus.cdb_tag = 5'd1; bus.cdb_val = vals[1]; end
         #1;
         checks++; if (bus.commit_en !== 1'b1 || bus.commit_tag !== 5'(i) || bus.commit_rd !== 5'(i + 1) || bus.commit_val !== vals[i])
            begin errors++; $display("FAIL order_commit%0d got en=%b tag=%0d rd=%0d val=%h want 1/%0d/%0d/%h",
                                     i, bus.commit_en, bus.commit_tag, bus.commit_rd, bus.commit_val, i, i + 1, vals[i]); end
         tick();
      end
      #1;
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL order_empty got %b want 1", bus.empty); end
   endtask

   task automatic test_full_wrap();
      do_reset();
      for (int i = 0; i < 32; i++) issue(1'b1, 5'(i));
      bus.issue_en = 1'b1; bus.cdb_en = 1'b1; bus.cdb_tag = 5'd0; bus.cdb_val = 32'hA0;
      #1;
      checks++; if (bus.full !== 1'b1 || bus.issue_tag !== 5'd0)
         begin errors++; $display("FAIL full_flag got full=%b tag=%0d want 1/0", bus.full, bus.issue_tag); end
      tick();
      bus.issue_en = 1'b1;
      #1;
      checks++; if (bus.full !== 1'b1 || bus.commit_en !== 1'b1 || bus.commit_tag !== 5'd0 || bus.commit_val !== 32'hA0)
         begin errors++; $display("FAIL full_retire got full=%b en=%b tag=%0d val=%h want 1/1/0/a0",
                                  bus.full, bus.commit_en, bus.commit_tag, bus.commit_val); end
      tick();
      #1;
      checks++; if (bus.full !== 1'b0 || bus.issue_tag !== 5'd0 || bus.empty !== 1'b0)
         begin errors++; $display("FAIL full_no_alloc got full=%b tag=%0d empty=%b want 0/0/0", bus.full, bus.issue_tag, bus.empty); end
      issue(1'b0, 5'd0);
      #1;
      checks++; if (bus.full !== 1'b1 || bus.issue_tag !== 5'd1)
         begin errors++; $display("FAIL full_wrap got full=%b tag=%0d want 1/1", bus.full, bus.issue_tag); end
   endtask

   task automatic test_flush();
      do_reset();
      bus.issue_is_branch = 1'b1; bus.issue_pred_taken = 1'b0; bus.issue_alt_pc = 32'h80;
      issue(1'b0, 5'd0);
      for (int i = 1; i < 4; i++) issue(1'b1, 5'd9);
      bus.cdb_en = 1'b1; bus.cdb_tag = 5'd0; bus.cdb_taken = 1'b1;
      tick();
      bus.issue_en = 1'b1; bus.cdb_en = 1'b1; bus.cdb_tag = 5'd1; bus.cdb_val = 32'h5;
      #1;
      checks++; if (bus.flush !== 1'b1 || bus.flush_pc !== 32'h80 || bus.commit_en !== 1'b0)
         begin errors++; $display("FAIL flush_pulse got flush=%b pc=%h en=%b want 1/80/0", bus.flush, bus.flush_pc, bus.commit_en); end
      tick();
      bus.query1_tag = 5'd1;
      #1;
      checks++; if (bus.flush !== 1'b0 || bus.flush_pc !== 32'h0)
         begin errors++; $display("FAIL flush_single got flush=%b pc=%h want 0/0", bus.flush, bus.flush_pc); end
      checks++; if (bus.empty !== 1'b1 || bus.issue_tag !== 5'd0 || bus.query1_ready !== 1'b0)
         begin errors++; $display("FAIL flush_after got empty=%b tag=%0d q1r=%b want 1/0/0", bus.empty, bus.issue_tag, bus.query1_ready); end
   endtask

   task automatic test_query();
      do_reset();
      for (int i = 0; i < 5; i++) issue(1'b1, 5'(i));
      bus.cdb_en = 1'b1; bus.cdb_tag = 5'd4; bus.cdb_val = 32'hBEEF;
      bus.query1_tag = 5'd4; bus.query2_tag = 5'd3;
      #1;
      checks++; if (bus.query1_ready !== 1'b1 || bus.query1_val !== 32'hBEEF)
         begin errors++; $display("FAIL query_bypass got r=%b v=%h want 1/beef", bus.query1_ready, bus.query1_val); end
      checks++; if (bus.query2_ready !== 1'b0) begin errors++; $display("FAIL query_unwritten got %b want 0", bus.query2_ready); end
      tick();
      bus.query1_tag = 5'd4; bus.query2_tag = 5'd10;
      #1;
      checks++; if (bus.query1_ready !== 1'b1 || bus.query1_val !== 32'hBEEF)
         begin errors++; $display("FAIL query_stored got r=%b v=%h want 1/beef", bus.query1_ready, bus.query1_val); end
      checks++; if (bus.query2_ready !== 1'b0) begin errors++; $display("FAIL query_invalid got %b want 0", bus.query2_ready); end
   endtask

   task automatic test_stall_reset();
      do_reset();
      issue(1'b1, 5'd7);
      bus.cdb_en = 1'b1; bus.cdb_tag = 5'd0; bus.cdb_val = 32'h55;
      tick();
      bus.hci_rdy = 1'b0; bus.issue_en = 1'b1;
      #1;
      checks++; if (bus.commit_en !== 1'b0 || bus.flush !== 1'b0)
         begin errors++; $display("FAIL stall_commit got en=%b flush=%b want 0/0", bus.commit_en, bus.flush); end
      tick();
      bus.hci_rdy = 1'b0;
      #1;
      checks++; if (bus.issue_tag !== 5'd1 || bus.empty !== 1'b0 || bus.commit_en !== 1'b0)
         begin errors++; $display("FAIL stall_hold got tag=%0d empty=%b en=%b want 1/0/0", bus.issue_tag, bus.empty, bus.commit_en); end
      tick();
      #1;
      checks++; if (bus.commit_en !== 1'b1 || bus.commit_rd !== 5'd7 || bus.commit_val !== 32'h55)
         begin errors++; $display("FAIL stall_release got en=%b rd=%0d val=%h want 1/7/55", bus.commit_en, bus.commit_rd, bus.commit_val); end
      tick();
      #1;
      checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL stall_empty got %b want 1", bus.empty); end
      issue(1'b1, 5'd1);
      issue(1'b1, 5'd2);
      rst = 1'b1; bus.hci_rdy = 1'b0; bus.issue_en = 1'b1;
      tick();
      #1;
      checks++; if (bus.empty !== 1'b1 || bus.issue_tag !== 5'd0)
         begin errors++; $display("FAIL midstream_reset got empty=%b tag=%0d want 1/0", bus.empty, bus.issue_tag); end
   endtask

   function automatic logic [4:0] pick_tag();
      if (mq.size() > 0 && $urandom_range(0, 4) != 0) return mq[$urandom_range(0, mq.size() - 1)].tag;
      return 5'($urandom);
   endfunction

   task automatic test_random();
      exp_t e;
      int   issue_pct;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         issue_pct = ((n / 400) % 2 == 1) ? 9 : 5;
         rst                  = ($urandom_range(0, 299) == 0);
         bus.hci_rdy          = ($urandom_range(0, 9) != 0);
         bus.issue_en         = ($urandom_range(0, 9) < issue_pct);
         bus.issue_has_dest   = 1'($urandom_range(0, 1));
         bus.issue_rd         = 5'($urandom);
         bus.issue_is_branch  = ($urandom_range(0, 3) == 0);
         bus.issue_pred_taken = 1'($urandom_range(0, 1));
         bus.issue_alt_pc     = $urandom;
         bus.cdb_en           = ($urandom_range(0, 9) < 6);
         bus.cdb_tag          = pick_tag();
         bus.cdb_val          = $urandom;
         bus.cdb_taken        = 1'($urandom_range(0, 1));
         bus.query1_tag       = pick_tag();
         bus.query2_tag       = pick_tag();
         #1;
         e = expect_now();
         checks++; if (bus.full !== e.full || bus.empty !== e.empty || bus.issue_tag !== e.issue_tag)
            begin errors++; $display("FAIL rnd_status cyc=%0d got full=%b empty=%b tag=%0d want %b/%b/%0d",
                                     n, bus.full, bus.empty, bus.issue_tag, e.full, e.empty, e.issue_tag); end
         checks++; if (bus.commit_en !== e.commit_en || bus.flush !== e.flush || bus.flush_pc !== e.flush_pc)
            begin errors++; $display("FAIL rnd_retire cyc=%0d got en=%b flush=%b pc=%h want %b/%b/%h",
                                     n, bus.commit_en, bus.flush, bus.flush_pc, e.commit_en, e.flush, e.flush_pc); end
         if (e.retire) begin
            checks++; if (bus.commit_rd !== e.c_rd || bus.commit_tag !== e.c_tag || bus.commit_val !== e.c_val)
               begin errors++; $display("FAIL rnd_commit cyc=%0d got rd=%0d tag=%0d val=%h want %0d/%0d/%h",
                                        n, bus.commit_rd, bus.commit_tag, bus.commit_val, e.c_rd, e.c_tag, e.c_val); end
         end
         checks++; if (bus.query1_ready !== e.q1r || (e.q1r && bus.query1_val !== e.q1v))
            begin errors++; $display("FAIL rnd_query1 cyc=%0d got r=%b v=%h want %b/%h", n, bus.query1_ready, bus.query1_val, e.q1r, e.q1v); end
         checks++; if (bus.query2_ready !== e.q2r || (e.q2r && bus.query2_val !== e.q2v))
            begin errors++; $display("FAIL rnd_query2 cyc=%0d got r=%b v=%h want %b/%h", n, bus.query2_ready, bus.query2_val, e.q2r, e.q2v); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_in_order();
      test_full_wrap();
      test_flush();
      test_query();
      test_stall_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
